pwm_encoder: RTL and testbench



---
 rtl/pwm_encoder.sv | 124 ++++++++++++
 tb/tb_pwm_encoder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_encoder.sv
// rtl/pwm_encoder.sv - double-buffered PWM generator with period-aligned duty updates
// and a run/stop FSM that always finishes the current period before idling.
module pwm_encoder #(
  parameter int PRESC_DIV = 196,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [CNT_W-1:0] duty_in,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic [CNT_W-1:0] duty_active,
  output logic             pwm_out,
  output logic             period_start,
  output logic             busy
);

  localparam int PW = (PRESC_DIV > 2) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PW-1:0]    PRESC_MAX = PW'(PRESC_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             pwm_q, pwm_d;
  logic             pstart_q, pstart_d;
  logic             load;
  logic             tick;
  logic             boundary;

  assign tick     = (state_q != S_IDLE) && (presc_q == PRESC_MAX);
  assign boundary = tick && (cnt_q == CNT_MAX);

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    cnt_d     = cnt_q;
    duty_d    = duty_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    pstart_d  = 1'b0;
    load      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d  = S_RUN;
          load     = 1'b1;
          pstart_d = 1'b1;
        end
      end
      S_RUN: begin
        if (!enable) state_d = S_STOP;
      end
      S_STOP: begin
        if (enable)        state_d = S_RUN;
        else if (boundary) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A boundary that drops us into idle ends the output, it does not start a period.
    if (boundary) begin
      load = 1'b1;
      if (state_d != S_IDLE) pstart_d = 1'b1;
    end

    if (state_q == S_IDLE) begin
      presc_d = '0;
      cnt_d   = '0;
    end else if (tick) begin
      presc_d = '0;
      cnt_d   = cnt_q + CNT_W'(1);
    end else begin
      presc_d = presc_q + PW'(1);
    end

    // Load needs pending=1 and accept needs pending=0, so they never collide.
    if (load && pending_q) begin
      duty_d    = shadow_q;
      pending_d = 1'b0;
    end else if (duty_valid && !pending_q) begin
      shadow_d  = duty_in;
      pending_d = 1'b1;
    end

    pwm_d = (state_d != S_IDLE) && (cnt_d < duty_d);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      cnt_q     <= '0;
      duty_q    <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      pwm_q     <= 1'b0;
      pstart_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      duty_q    <= duty_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      pwm_q     <= pwm_d;
      pstart_q  <= pstart_d;
    end
  end

  assign duty_ready   = !pending_q;
  assign duty_active  = duty_q;
  assign pwm_out      = pwm_q;
  assign period_start = pstart_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_pwm_encoder.sv
// tb/tb_pwm_encoder.sv - directed and randomized checks of pwm_encoder against
// a phase-counter reference model.
module tb_pwm_encoder;

  localparam int PRESC = 4;
  localparam int CW    = 8;
  localparam int PER   = PRESC * (1 << CW);

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [CW-1:0] duty_in;
  logic          duty_valid;
  logic          duty_ready;
  logic [CW-1:0] duty_active;
  logic          pwm_out;
  logic          period_start;
  logic          busy;

  int vectors     = 0;
  int miscompares = 0;
  int hi;
  bit chk_en = 1'b0;

  pwm_encoder #(.PRESC_DIV(PRESC), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .duty_in      (duty_in),
    .duty_valid   (duty_valid),
    .duty_ready   (duty_ready),
    .duty_active  (duty_active),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Reference: one phase counter over the whole clk-level period, not presc+cnt.
  bit          m_act, m_stop, m_pend, m_pwm, m_ps, m_acc, m_last;
  int          m_ph;
  logic [CW-1:0] m_duty, m_sh;

  always @(posedge clk) begin
    if (!rst) begin
      m_act = 0; m_stop = 0; m_pend = 0; m_pwm = 0; m_ps = 0;
      m_ph = 0; m_duty = '0; m_sh = '0;
    end else begin
      m_acc = duty_valid && !m_pend;
      m_ps  = 0;
      if (!m_act) begin
        if (enable) begin
          m_act = 1; m_stop = 0; m_ph = 0; m_ps = 1;
          if (m_pend) begin m_duty = m_sh; m_pend = 0; end
        end
      end else begin
        m_last = (m_ph == PER - 1);
        m_ph   = m_last ? 0 : m_ph + 1;
        if (m_last) begin
          if (m_pend) begin m_duty = m_sh; m_pend = 0; end
          if (m_stop && !enable) m_act = 0;
          else m_ps = 1;
        end
        m_stop = m_act && !enable;
      end
      if (m_acc) begin m_sh = duty_in; m_pend = 1; end
      m_pwm = m_act && ((m_ph / PRESC) < int'(m_duty));
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if ({pwm_out, period_start, busy, duty_ready, duty_active} !==
          {m_pwm, m_ps, m_act, !m_pend, m_duty}) begin
        miscompares++;
        $display("FAIL model t=%0t: pwm/ps/busy/rdy/duty got %b/%b/%b/%b/%0d expected %b/%b/%b/%b/%0d",
                 $time, pwm_out, period_start, busy, duty_ready, duty_active,
                 m_pwm, m_ps, m_act, !m_pend, m_duty);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input int v);
    int k = 0;
    duty_in    = CW'(v);
    duty_valid = 1'b1;
    while (!duty_ready && k < 5000) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    duty_valid = 1'b0;
    if (k >= 5000) chk("send_timeout", k, 0);
  endtask

  task automatic wait_ps();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!period_start && k < 5000);
    if (k >= 5000) chk("period_start_timeout", k, 0);
  endtask

  task automatic count_period();
    hi = 0;
    for (int i = 0; i < PER; i++) begin
      if (i != 0) @(negedge clk);
      hi += int'(pwm_out);
    end
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; duty_valid = 1'b0; duty_in = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_pwm", pwm_out, 0);
    chk("reset_ps", period_start, 0);
    chk("reset_busy", busy, 0);
    chk("reset_ready", duty_ready, 1);
    chk("reset_duty", duty_active, 0);
    rst = 1'b1;

    send(64);
    chk("idle_pending_ready", duty_ready, 0);
    enable = 1'b1;
    wait_ps();
    chk("p1_duty_active", duty_active, 64);
    count_period();
    chk("p1_high_clk", hi, 256);

    wait_ps();
    fork
      count_period();
      begin
        repeat (100) @(negedge clk);
        send(192);
        chk("p2_ready_drop", duty_ready, 0);
      end
    join
    chk("p2_high_clk", hi, 256);

    wait_ps();
    chk("p3_ready_back", duty_ready, 1);
    fork
      count_period();
      begin
        repeat (100) @(negedge clk);
        send(10);
        duty_in = 8'd20;
        duty_valid = 1'b1;
      end
    join
    chk("p3_high_clk", hi, 768);

    wait_ps();
    chk("p4_duty_active", duty_active, 10);
    fork
      count_period();
      begin
        @(negedge clk);
        chk("p4_held_accepted", duty_ready, 0);
        duty_valid = 1'b0;
      end
    join
    chk("p4_high_clk", hi, 40);

    wait_ps();
    fork
      count_period();
      begin
        repeat (100) @(negedge clk);
        send(0);
        duty_in = 8'd255;
        duty_valid = 1'b1;
      end
    join
    chk("p5_high_clk", hi, 80);

    wait_ps();
    fork
      count_period();
      begin
        @(negedge clk);
        duty_valid = 1'b0;
      end
    join
    chk("p6_duty0_high_clk", hi, 0);

    wait_ps();
    chk("p7_duty_active", duty_active, 255);
    fork
      count_period();
      begin
        repeat (400) @(negedge clk);
        enable = 1'b0;
      end
    join
    chk("p7_stop_high_clk", hi, 1020);
    @(negedge clk);
    chk("stop_idle_busy", busy, 0);
    chk("stop_idle_pwm", pwm_out, 0);
    chk("stop_idle_ps", period_start, 0);

    repeat (5) @(negedge clk);
    enable = 1'b1;
    wait_ps();
    fork
      count_period();
      begin
        repeat (400) @(negedge clk);
        enable = 1'b0;
        repeat (400) @(negedge clk);
        enable = 1'b1;
      end
    join
    chk("p8_resume_high_clk", hi, 1020);
    @(negedge clk);
    chk("resume_ps_on_schedule", period_start, 1);
    chk("resume_busy", busy, 1);

    repeat (300) @(negedge clk);
    send(77);
    chk("pre_reset_pending", duty_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("midreset_pwm", pwm_out, 0);
    chk("midreset_ps", period_start, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_ready", duty_ready, 1);
    chk("midreset_duty", duty_active, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset_ps", period_start, 1);
    chk("post_reset_discarded", duty_active, 0);

    for (int c = 0; c < 40000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 6999) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 699) == 0) enable = ~enable;
      if (duty_valid && duty_ready) begin
        if ($urandom_range(0, 1) == 0) duty_valid = 1'b0;
      end else if (!duty_valid && $urandom_range(0, 299) == 0) begin
        case ($urandom_range(0, 3))
          0: duty_in = 8'd0;
          1: duty_in = 8'd255;
          default: duty_in = CW'($urandom_range(0, 255));
        endcase
        duty_valid = 1'b1;
      end
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
